// File: rtl/buf_pkg.sv
// Shared types for the 8-entry byte buffer and its downstream drain framer.
package buf_pkg;
    localparam int DATA_W    = 8;
    localparam int BUF_DEPTH = 8;

    typedef logic [DATA_W-1:0] byte_t;

    typedef struct packed {
        byte_t data;
        logic  last;
        logic  valid;
    } slot_t;
endpackage

// File: rtl/drain_out_slice.sv
// Output register of the drain framer: holds one byte on a valid/ready stream.
module drain_out_slice
    import buf_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  load_i,
    input  byte_t data_i,
    input  logic  last_i,
    input  logic  ready_i,
    output logic  free_o,
    output slot_t slot_o,
    output logic  frame_done_o
);
    slot_t slot_q, slot_d;
    logic  done_q;

    // A byte transfers when valid && ready; data/last hold while valid && !ready,
    // and a load may land in the same cycle as the accept.
    assign free_o = !slot_q.valid || ready_i;

    always_comb begin
        slot_d = slot_q;
        if (load_i) begin
            slot_d.data  = data_i;
            slot_d.last  = last_i;
            slot_d.valid = 1'b1;
        end else if (ready_i) begin
            slot_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q <= '0;
            done_q <= 1'b0;
        end else begin
            slot_q <= slot_d;
            done_q <= slot_q.valid && ready_i && slot_q.last;
        end
    end

    assign slot_o       = slot_q;
    assign frame_done_o = done_q;
endmodule

// File: rtl/buffer_drain_framer.sv
// Pops bytes from the buffer and frames them, with a one-byte lookahead so an
// idle timeout can still mark the final byte of a short frame as last.
module buffer_drain_framer #(
    parameter int DATA_W  = buf_pkg::DATA_W,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 16,
    parameter int TMR_W   = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              EN,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic              buf_empty,
    input  logic [DATA_W-1:0] buf_data,
    output logic              buf_rd,
    output logic              buf_wr_inhibit,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic              frame_done
);
    localparam logic [TMR_W-1:0] TMR_END = TMR_W'(TIMEOUT - 1);

    logic              inflight_q;
    logic [DATA_W-1:0] stg_q, stg_d;
    logic              stg_v_q, stg_v_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  len_m1_q, len_m1_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;

    logic              out_free, out_load, out_last;
    logic              idle, issue, known_last, tmo_hit;
    buf_pkg::slot_t    out_slot;

    assign idle       = buf_empty || !EN;
    assign issue      = EN && !buf_empty && !inflight_q && (!stg_v_q || out_free);
    assign known_last = stg_v_q && (idx_q == len_m1_q);
    assign tmo_hit    = stg_v_q && idle && (tmr_q == TMR_END);

    always_comb begin
        stg_d    = stg_q;
        stg_v_d  = stg_v_q;
        idx_d    = idx_q;
        len_m1_d = len_m1_q;
        tmr_d    = tmr_q;
        out_load = 1'b0;
        out_last = 1'b0;
        if (inflight_q) begin
            // Capture: the lookahead byte proves the staged one is not last.
            tmr_d   = '0;
            stg_d   = buf_data;
            stg_v_d = 1'b1;
            if (stg_v_q) begin
                out_load = 1'b1;
                idx_d    = idx_q + LEN_W'(1);
            end else if (idx_q == '0) begin
                len_m1_d = frame_len - LEN_W'(1);
            end
        end else if ((known_last || tmo_hit) && out_free) begin
            out_load = 1'b1;
            out_last = 1'b1;
            stg_v_d  = 1'b0;
            idx_d    = '0;
            tmr_d    = '0;
        end else if (stg_v_q && idle && (tmr_q != TMR_END)) begin
            tmr_d = tmr_q + TMR_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            inflight_q <= 1'b0;
            stg_q      <= '0;
            stg_v_q    <= 1'b0;
            idx_q      <= '0;
            len_m1_q   <= '1;
            tmr_q      <= '0;
        end else begin
            inflight_q <= issue;
            stg_q      <= stg_d;
            stg_v_q    <= stg_v_d;
            idx_q      <= idx_d;
            len_m1_q   <= len_m1_d;
            tmr_q      <= tmr_d;
        end
    end

    drain_out_slice u_out (
        .clk_i        (Clk),
        .rst_i        (Rst),
        .load_i       (out_load),
        .data_i       (stg_q),
        .last_i       (out_last),
        .ready_i      (m_ready),
        .free_o       (out_free),
        .slot_o       (out_slot),
        .frame_done_o (frame_done)
    );

    assign buf_rd         = inflight_q;
    assign buf_wr_inhibit = inflight_q;
    assign m_data         = out_slot.data;
    assign m_last         = out_slot.last;
    assign m_valid        = out_slot.valid;
endmodule

// File: tb/tb_buffer_drain_framer.sv
// Self-checking bench: FIFO-mode buffer model, frame-rule scoreboard, random streams.
module tb_buffer_drain_framer;
    localparam int DW  = 8;
    localparam int LW  = 4;
    localparam int TMO = 16;
    localparam int TW  = 5;

    logic          Clk = 1'b0;
    logic          Rst, EN, buf_empty, buf_rd, buf_wr_inhibit;
    logic          m_valid, m_last, m_ready, frame_done;
    logic [LW-1:0] frame_len;
    logic [DW-1:0] buf_data, m_data;

    always #5 Clk = ~Clk;

    buffer_drain_framer #(.DATA_W(DW), .LEN_W(LW), .TIMEOUT(TMO), .TMR_W(TW)) dut (
        .Clk(Clk), .Rst(Rst), .EN(EN), .frame_len(frame_len),
        .buf_empty(buf_empty), .buf_data(buf_data), .buf_rd(buf_rd),
        .buf_wr_inhibit(buf_wr_inhibit), .m_data(m_data), .m_valid(m_valid),
        .m_last(m_last), .m_ready(m_ready), .frame_done(frame_done)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Buffer model (FIFO mode): pop on the negedge inside the RD cycle; a
    // write in the same cycle as RD wins and the RD is lost.
    logic [DW-1:0] buf_q[$];
    logic [DW-1:0] feed_q[$];
    int rd_cnt    = 0;
    int empty_cyc = 0;

    initial begin
        buf_empty = 1'b1;
        buf_data  = '0;
    end

    always @(negedge Clk) begin
        if (buf_rd === 1'b1) begin
            rd_cnt++;
            check_eq("rd_while_empty", buf_empty, 1'b0);
        end
        if (buf_wr_inhibit !== 1'b1 && feed_q.size() > 0 && buf_q.size() < 8) begin
            buf_q.push_back(feed_q.pop_front());
        end else if (buf_rd === 1'b1 && buf_q.size() > 0) begin
            buf_data = buf_q.pop_front();
            if (buf_q.size() == 0) empty_cyc = cyc;
        end
        buf_empty = (buf_q.size() == 0);
    end

    // Scoreboard: {last, data} in the order bytes were written to the buffer.
    logic [DW:0]   exp_q[$];
    int            acc_cyc[$];
    int            done_cnt = 0;
    logic          pv = 1'b0, pr = 1'b0, pl = 1'b0, pacc_last = 1'b0;
    logic [DW-1:0] pd = '0;
    logic [DW:0]   e;

    always @(negedge Clk) begin
        if (Rst !== 1'b0) begin
            pv        = 1'b0;
            pr        = 1'b0;
            pacc_last = 1'b0;
        end else begin
            check_eq("frame_done", frame_done, pacc_last);
            if (frame_done === 1'b1) done_cnt++;
            if (pv && !pr) begin
                check_eq("hold_valid", m_valid, 1'b1);
                check_eq("hold_data", m_data, pd);
                check_eq("hold_last", m_last, pl);
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                acc_cyc.push_back(cyc);
                check_eq("byte_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("m_data", m_data, e[DW-1:0]);
                    check_eq("m_last", m_last, e[DW]);
                end
            end
            pacc_last = m_valid && m_ready && m_last;
            pv = m_valid;
            pr = m_ready;
            pd = m_data;
            pl = m_last;
        end
    end

    // m_ready driver: 0 = always high, 1 = random, 2 = held low.
    int ready_mode = 0;
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            case (ready_mode)
                1:       m_ready = ($urandom_range(0, 3) != 0);
                2:       m_ready = 1'b0;
                default: m_ready = 1'b1;
            endcase
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        step(2);
        Rst = 1'b0;
    endtask

    task automatic load(input logic [DW-1:0] b, input logic last);
        feed_q.push_back(b);
        exp_q.push_back({last, b});
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || feed_q.size() != 0 || buf_q.size() != 0) && n < budget) begin
            step(1);
            n++;
        end
        check_eq("drain_complete", exp_q.size(), 0);
        step(TMO + 4);
    endtask

    initial begin
        int n;
        int len;
        Rst       = 1'b1;
        EN        = 1'b0;
        frame_len = 4'd2;

        // Reset behaviour: 3 bytes waiting, EN high while Rst is held.
        load(8'h01, 1'b0); load(8'h02, 1'b1); load(8'h03, 1'b1);
        step(5);
        EN = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1);
            check_eq("rst_buf_rd", buf_rd, 1'b0);
            check_eq("rst_m_valid", m_valid, 1'b0);
            check_eq("rst_m_data", m_data, 8'h00);
            check_eq("rst_frame_done", frame_done, 1'b0);
        end
        done_cnt = 0;
        Rst = 1'b0;
        drain(300);
        check_eq("rst_frames", done_cnt, 2);

        // Full frames of two.
        do_reset();
        EN = 1'b0;
        frame_len = 4'd2;
        load(8'h11, 1'b0); load(8'h22, 1'b1); load(8'h33, 1'b0); load(8'h44, 1'b1);
        step(6);
        rd_cnt = 0;
        done_cnt = 0;
        EN = 1'b1;
        drain(300);
        check_eq("full_rd_pulses", rd_cnt, 4);
        check_eq("full_frames", done_cnt, 2);

        // Short frame closed by idle timeout.
        do_reset();
        EN = 1'b0;
        frame_len = 4'd4;
        load(8'hA1, 1'b0); load(8'hA2, 1'b1);
        step(4);
        acc_cyc.delete();
        EN = 1'b1;
        drain(300);
        check_eq("tmo_accepts", acc_cyc.size(), 2);
        if (acc_cyc.size() >= 2) begin
            // A1 leaves on the capture of A2; A2 after TIMEOUT idle cycles past that capture.
            check_eq("tmo_a1_time", acc_cyc[0] - empty_cyc, 1);
            check_eq("tmo_a2_time", acc_cyc[1] - empty_cyc, TMO + 1);
        end

        // Backpressure: only stg and out may fill while m_ready is low.
        do_reset();
        EN = 1'b0;
        frame_len = 4'd3;
        ready_mode = 2;
        load(8'h51, 1'b0); load(8'h52, 1'b0); load(8'h53, 1'b1);
        load(8'h54, 1'b0); load(8'h55, 1'b1);
        step(8);
        rd_cnt = 0;
        done_cnt = 0;
        EN = 1'b1;
        step(10);
        check_eq("bp_pops", rd_cnt, 2);
        check_eq("bp_valid", m_valid, 1'b1);
        ready_mode = 0;
        drain(300);
        check_eq("bp_frames", done_cnt, 2);

        // Mid-frame length change is ignored until the next frame starts.
        do_reset();
        EN = 1'b0;
        frame_len = 4'd4;
        load(8'h61, 1'b0); load(8'h62, 1'b0); load(8'h63, 1'b0); load(8'h64, 1'b1);
        load(8'h65, 1'b0); load(8'h66, 1'b1);
        step(8);
        EN = 1'b1;
        n = 0;
        while (buf_rd !== 1'b1 && n < 50) begin
            step(1);
            n++;
        end
        check_eq("len_first_rd", buf_rd, 1'b1);
        step(1);
        frame_len = 4'd2;
        drain(300);

        // Random streams with random backpressure and the write-inhibit honoured.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            len = $urandom_range(1, 16);
            frame_len = len[LW-1:0];
            ready_mode = 1;
            EN = 1'b1;
            for (int k = 0; k < 64; k++) begin
                load(DW'($urandom), ((k + 1) % len == 0) || (k == 63));
            end
            drain(5000);
            ready_mode = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
